// File: rtl/txtrigger_pkg.sv
// Shared trigger definitions: scheduler state encoding, trigger bus widths and
// the default busy-wait timeout, common to the scheduler and the trigger controller.
package txtrigger_pkg;

    localparam int unsigned TXT_CKINI_W      = 10;
    localparam int unsigned TXT_CKPER_W      = 10;
    localparam int unsigned TXT_NPER_W       = 5;
    localparam int unsigned TXT_WAIT_TMO_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WAITB = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4,
        ST_GAP   = 3'd5
    } txsched_state_e;

    // Counter width able to hold values 0..max_val, never narrower than one bit.
    function automatic int unsigned cnt_bits(input int unsigned max_val);
        int unsigned w;
        w = $clog2(max_val + 32'd1);
        if (w < 32'd1) begin
            w = 32'd1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/txsched_rr_arb.sv
// Two-requester round-robin selector: rr_i names the side preferred on a tie.
module txsched_rr_arb (
    input  logic req_a_i,
    input  logic req_b_i,
    input  logic rr_i,
    output logic grant_b_o,
    output logic any_o
);

    assign any_o     = req_a_i | req_b_i;
    assign grant_b_o = req_b_i & (~req_a_i | rr_i);

endmodule

// File: rtl/txtrigger_sched.sv
// Burst scheduler sharing one trigger controller between requesters A and B.
// Optional macro TXSCHED_GAP_EN inserts a guard GAP state after every burst.
module txtrigger_sched
    import txtrigger_pkg::*;
#(
    parameter int unsigned WAIT_TMO   = TXT_WAIT_TMO_DEF,
    parameter int unsigned GAP_CYCLES = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req_a,
    input  logic                   req_b,
    input  logic [TXT_CKINI_W-1:0] cfg_a_ckini,
    input  logic [TXT_CKINI_W-1:0] cfg_b_ckini,
    input  logic [TXT_CKPER_W-1:0] cfg_a_ckper,
    input  logic [TXT_CKPER_W-1:0] cfg_b_ckper,
    input  logic [TXT_NPER_W-1:0]  cfg_a_nper,
    input  logic [TXT_NPER_W-1:0]  cfg_b_nper,
    output logic                   ack_a,
    output logic                   ack_b,
    output logic                   done_a,
    output logic                   done_b,
    output logic                   trg_start,
    output logic [TXT_CKINI_W-1:0] trg_ckini,
    output logic [TXT_CKPER_W-1:0] trg_ckper,
    output logic [TXT_NPER_W-1:0]  trg_nper,
    input  logic                   trg_busy,
    output logic                   owner,
    output logic                   sched_busy,
    output logic                   err,
    input  logic                   err_clr
);

    // One counter serves both the busy wait and the guard gap, so size it for the larger.
    localparam int unsigned CNT_MAX = (WAIT_TMO > GAP_CYCLES) ? WAIT_TMO : GAP_CYCLES;
    localparam int unsigned CNT_W   = cnt_bits(CNT_MAX);

    txsched_state_e          state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    rr_q, rr_d;
    logic                    owner_q, owner_d;
    logic                    err_q, err_d;
    logic [TXT_CKINI_W-1:0]  ckini_q, ckini_d;
    logic [TXT_CKPER_W-1:0]  ckper_q, ckper_d;
    logic [TXT_NPER_W-1:0]   nper_q, nper_d;
    logic                    ack_a_q, ack_a_d;
    logic                    ack_b_q, ack_b_d;
    logic                    done_a_q, done_a_d;
    logic                    done_b_q, done_b_d;
    logic                    start_q, start_d;
    logic                    busy_q, busy_d;
    logic                    grant_b_s;
    logic                    any_req_s;
    logic                    timeout_s;

    txsched_rr_arb u_arb (
        .req_a_i   (req_a),
        .req_b_i   (req_b),
        .rr_i      (rr_q),
        .grant_b_o (grant_b_s),
        .any_o     (any_req_s)
    );

    // Next-state, latched configuration and registered output decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = {CNT_W{1'b0}};
        rr_d      = rr_q;
        owner_d   = owner_q;
        ckini_d   = ckini_q;
        ckper_d   = ckper_q;
        nper_d    = nper_q;
        timeout_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_d = ST_LOAD;
                    owner_d = grant_b_s;
                    ckini_d = grant_b_s ? cfg_b_ckini : cfg_a_ckini;
                    ckper_d = grant_b_s ? cfg_b_ckper : cfg_a_ckper;
                    nper_d  = grant_b_s ? cfg_b_nper  : cfg_a_nper;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (nper_q != {TXT_NPER_W{1'b0}}) begin
                    state_d = ST_WAITB;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_WAITB: begin
                if (trg_busy) begin
                    state_d = ST_RUN;
                end else if (cnt_q == CNT_W'(WAIT_TMO - 32'd1)) begin
                    state_d   = ST_DONE;
                    timeout_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (trg_busy) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                rr_d = ~owner_q;
`ifdef TXSCHED_GAP_EN
                state_d = ST_GAP;
`else
                state_d = ST_IDLE;
`endif
            end
`ifdef TXSCHED_GAP_EN
            ST_GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 32'd1)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A timeout in the same cycle as a clear request keeps the flag set.
        if (timeout_s) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end

        ack_a_d  = (state_d == ST_LOAD) & ~owner_d;
        ack_b_d  = (state_d == ST_LOAD) &  owner_d;
        start_d  = (state_d == ST_LOAD) & (nper_d != {TXT_NPER_W{1'b0}});
        done_a_d = (state_d == ST_DONE) & ~owner_d;
        done_b_d = (state_d == ST_DONE) &  owner_d;
        busy_d   = (state_d != ST_IDLE);
    end

    // State, configuration and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            rr_q     <= 1'b0;
            owner_q  <= 1'b0;
            err_q    <= 1'b0;
            ckini_q  <= {TXT_CKINI_W{1'b0}};
            ckper_q  <= {TXT_CKPER_W{1'b0}};
            nper_q   <= {TXT_NPER_W{1'b0}};
            ack_a_q  <= 1'b0;
            ack_b_q  <= 1'b0;
            done_a_q <= 1'b0;
            done_b_q <= 1'b0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_q     <= rr_d;
            owner_q  <= owner_d;
            err_q    <= err_d;
            ckini_q  <= ckini_d;
            ckper_q  <= ckper_d;
            nper_q   <= nper_d;
            ack_a_q  <= ack_a_d;
            ack_b_q  <= ack_b_d;
            done_a_q <= done_a_d;
            done_b_q <= done_b_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
        end
    end

    assign ack_a      = ack_a_q;
    assign ack_b      = ack_b_q;
    assign done_a     = done_a_q;
    assign done_b     = done_b_q;
    assign trg_start  = start_q;
    assign trg_ckini  = ckini_q;
    assign trg_ckper  = ckper_q;
    assign trg_nper   = nper_q;
    assign owner      = owner_q;
    assign sched_busy = busy_q;
    assign err        = err_q;

endmodule

// File: tb/tb_txtrigger_sched.sv
// Directed self-checking bench for txtrigger_sched (default build, WAIT_TMO=4).
module tb_txtrigger_sched;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req_a = 1'b0;
    logic       req_b = 1'b0;
    logic [9:0] cfg_a_ckini = 10'd0;
    logic [9:0] cfg_b_ckini = 10'd0;
    logic [9:0] cfg_a_ckper = 10'd0;
    logic [9:0] cfg_b_ckper = 10'd0;
    logic [4:0] cfg_a_nper  = 5'd0;
    logic [4:0] cfg_b_nper  = 5'd0;
    logic       ack_a, ack_b, done_a, done_b, trg_start;
    logic [9:0] trg_ckini, trg_ckper;
    logic [4:0] trg_nper;
    logic       trg_busy = 1'b0;
    logic       owner, sched_busy, err;
    logic       err_clr = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    txtrigger_sched #(.WAIT_TMO(4), .GAP_CYCLES(8)) dut (
        .clock(clock), .reset(reset),
        .req_a(req_a), .req_b(req_b),
        .cfg_a_ckini(cfg_a_ckini), .cfg_b_ckini(cfg_b_ckini),
        .cfg_a_ckper(cfg_a_ckper), .cfg_b_ckper(cfg_b_ckper),
        .cfg_a_nper(cfg_a_nper), .cfg_b_nper(cfg_b_nper),
        .ack_a(ack_a), .ack_b(ack_b), .done_a(done_a), .done_b(done_b),
        .trg_start(trg_start), .trg_ckini(trg_ckini), .trg_ckper(trg_ckper),
        .trg_nper(trg_nper), .trg_busy(trg_busy),
        .owner(owner), .sched_busy(sched_busy), .err(err), .err_clr(err_clr)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs and samples both happen 1ns after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        check_eq("rst_busy",  {31'd0, sched_busy}, 32'd0);
        check_eq("rst_owner", {31'd0, owner}, 32'd0);
        check_eq("rst_err",   {31'd0, err}, 32'd0);
        check_eq("rst_ckini", {22'd0, trg_ckini}, 32'd0);
        check_eq("rst_start", {31'd0, trg_start}, 32'd0);

        // Single A burst, busy held 20 cycles.
        cfg_a_ckini = 10'd3; cfg_a_ckper = 10'd5; cfg_a_nper = 5'd2;
        req_a = 1'b1;
        tick();
        check_eq("a_ack",   {31'd0, ack_a}, 32'd1);
        check_eq("a_start", {31'd0, trg_start}, 32'd1);
        check_eq("a_ckini", {22'd0, trg_ckini}, 32'd3);
        check_eq("a_ckper", {22'd0, trg_ckper}, 32'd5);
        check_eq("a_nper",  {27'd0, trg_nper}, 32'd2);
        check_eq("a_owner", {31'd0, owner}, 32'd0);
        check_eq("a_sbusy", {31'd0, sched_busy}, 32'd1);
        trg_busy = 1'b1;
        tick();
        check_eq("a_start_1cyc", {31'd0, trg_start}, 32'd0);
        check_eq("a_ack_1cyc",   {31'd0, ack_a}, 32'd0);
        for (int i = 0; i < 19; i++) tick();
        check_eq("a_no_done_run", {31'd0, done_a}, 32'd0);
        trg_busy = 1'b0;
        tick();
        check_eq("a_done", {31'd0, done_a}, 32'd1);
        req_a = 1'b0;
        tick();
        check_eq("a_done_1cyc", {31'd0, done_a}, 32'd0);
        check_eq("a_idle",      {31'd0, sched_busy}, 32'd0);

        // Both requesting from reset: A, B, A alternation.
        do_reset();
        cfg_a_ckini = 10'd7; cfg_a_nper = 5'd1;
        cfg_b_ckini = 10'd9; cfg_b_nper = 5'd1;
        req_a = 1'b1; req_b = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("rr_ack_a", {31'd0, ack_a}, (k == 1) ? 32'd0 : 32'd1);
            check_eq("rr_ack_b", {31'd0, ack_b}, (k == 1) ? 32'd1 : 32'd0);
            check_eq("rr_owner", {31'd0, owner}, (k == 1) ? 32'd1 : 32'd0);
            check_eq("rr_ckini", {22'd0, trg_ckini}, (k == 1) ? 32'd9 : 32'd7);
            trg_busy = 1'b1;
            tick();
            tick();
            trg_busy = 1'b0;
            tick();
            check_eq("rr_done_a", {31'd0, done_a}, (k == 1) ? 32'd0 : 32'd1);
            check_eq("rr_done_b", {31'd0, done_b}, (k == 1) ? 32'd1 : 32'd0);
            if (k == 2) begin
                req_a = 1'b0; req_b = 1'b0;
            end
            tick();
        end

        // B with zero pulses: no start, done two cycles after leaving IDLE.
        cfg_b_nper = 5'd0;
        req_b = 1'b1;
        tick();
        check_eq("z_ack_b", {31'd0, ack_b}, 32'd1);
        check_eq("z_start", {31'd0, trg_start}, 32'd0);
        tick();
        check_eq("z_done_b", {31'd0, done_b}, 32'd1);
        check_eq("z_start2", {31'd0, trg_start}, 32'd0);
        req_b = 1'b0;
        tick();
        check_eq("z_idle", {31'd0, sched_busy}, 32'd0);

        // Controller never answers: timeout after 4 WAITB cycles.
        cfg_a_nper = 5'd3;
        req_a = 1'b1;
        tick();
        check_eq("t_start", {31'd0, trg_start}, 32'd1);
        for (int i = 0; i < 4; i++) tick();
        check_eq("t_err_early", {31'd0, err}, 32'd0);
        check_eq("t_done_early", {31'd0, done_a}, 32'd0);
        tick();
        check_eq("t_err", {31'd0, err}, 32'd1);
        check_eq("t_done", {31'd0, done_a}, 32'd1);
        req_a = 1'b0;
        tick();
        check_eq("t_err_sticky", {31'd0, err}, 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_eq("t_err_clr", {31'd0, err}, 32'd0);

        // Reset while running abandons the burst.
        cfg_a_nper = 5'd2; cfg_a_ckini = 10'd3;
        req_a = 1'b1;
        tick();
        trg_busy = 1'b1;
        tick();
        tick();
        tick();
        check_eq("r_run_busy", {31'd0, sched_busy}, 32'd1);
        reset = 1'b1;
        #1;
        check_eq("r_busy0",  {31'd0, sched_busy}, 32'd0);
        check_eq("r_ckini0", {22'd0, trg_ckini}, 32'd0);
        check_eq("r_nper0",  {27'd0, trg_nper}, 32'd0);
        req_a = 1'b0; trg_busy = 1'b0;
        tick();
        check_eq("r_no_done", {31'd0, done_a}, 32'd0);
        reset = 1'b0;
        cfg_b_ckini = 10'd11; cfg_b_ckper = 10'd4; cfg_b_nper = 5'd1;
        req_b = 1'b1;
        tick();
        check_eq("r_ack_b",  {31'd0, ack_b}, 32'd1);
        check_eq("r_owner",  {31'd0, owner}, 32'd1);
        check_eq("r_ckini",  {22'd0, trg_ckini}, 32'd11);
        trg_busy = 1'b1;
        tick();
        tick();
        trg_busy = 1'b0;
        tick();
        check_eq("r_done_b", {31'd0, done_b}, 32'd1);
        req_b = 1'b0;
        tick();
        check_eq("r_idle", {31'd0, sched_busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
